// File: rtl/reshape_pkg.sv
// Shared types and default frame geometry for the reshape (serializer/deserializer) blocks.
package reshape_pkg;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        DISCARD
    } reshape_state_t;

    localparam int unsigned RESHAPE_FRAME_LEN = 40;
    localparam int unsigned RESHAPE_SAMPLE_W  = 16;

endpackage

// File: rtl/reshape_input.sv
// Stream-to-frame deserializer: collects N_OUT samples into one parallel frame.
// Define RESHAPE_INPUT_LAST_CHECK_EN to enable s_last framing checks (err_short/err_long).
module reshape_input
    import reshape_pkg::*;
#(
    parameter int unsigned N_OUT = RESHAPE_FRAME_LEN,
    parameter int unsigned WIDTH = RESHAPE_SAMPLE_W,
    parameter int unsigned CNT_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in [1],
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [WIDTH-1:0] out [N_OUT],
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err_short,
    output logic             err_long
);

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(N_OUT - 1);

    reshape_state_t   state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] banks_q [N_OUT];
    logic [WIDTH-1:0] banks_d [N_OUT];
    logic             long_q, long_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             accept;

    assign s_ready   = (state_q == FILL) || (state_q == DISCARD);
    assign m_valid   = (state_q == HOLD);
    assign accept    = s_valid && s_ready;
    assign out       = banks_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        banks_d     = banks_q;
        long_d      = long_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    banks_d[count_q] = in[0];
`ifdef RESHAPE_INPUT_LAST_CHECK_EN
                    if (s_last && (count_q != LastBeat)) begin
                        // Short frame: drop the partial frame and restart at beat 0.
                        err_short_d = 1'b1;
                        count_d     = '0;
                    end else
`endif
                    if (count_q == LastBeat) begin
                        count_d = '0;
                        state_d = HOLD;
`ifdef RESHAPE_INPUT_LAST_CHECK_EN
                        if (!s_last) begin
                            err_long_d = 1'b1;
                            long_d     = 1'b1;
                        end
`endif
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = long_q ? DISCARD : FILL;
                end
            end
            DISCARD: begin
                // Only reachable after a long frame; drop beats until the upstream frame ends.
                if (accept && s_last) begin
                    long_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            long_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            for (int i = 0; i < int'(N_OUT); i++) begin
                banks_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            long_q      <= long_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            banks_q     <= banks_d;
        end
    end

endmodule

// File: tb/tb_reshape_input.sv
// Directed self-checking bench for reshape_input (default 40 x 16-bit frames).
module tb_reshape_input;

    localparam int N = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_s [1];
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [15:0] out_s [N];
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        err_short;
    logic        err_long;

    int tests = 0;
    int fails = 0;
    int short_cnt = 0;
    int long_cnt = 0;
    int frame_cnt = 0;

    reshape_input #(.N_OUT(N), .WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .out      (out_s),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_short(err_short),
        .err_long (err_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (err_short) short_cnt++;
            if (err_long) long_cnt++;
            if (m_valid && m_ready) frame_cnt++;
        end
    end

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic push(input logic [15:0] d, input logic l);
        int n = 0;
        s_valid  = 1'b1;
        in_s[0]  = d;
        s_last   = l;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || err_short !== 1'b0 || err_long !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: s_ready=%b m_valid=%b es=%b el=%b required 1 0 0 0",
                     s_ready, m_valid, err_short, err_long);
        end
        tests++;
        if (out_s[0] !== 16'd0 || out_s[N-1] !== 16'd0) begin
            fails++;
            $display("FAIL reset_banks: out0=%0d out39=%0d required 0 0", out_s[0], out_s[N-1]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        int s0 = short_cnt;
        int l0 = long_cnt;
        int bad = 0;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) push(16'(i), i == N - 1);
        tests++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: m_valid=%b s_ready=%b required 1 0", m_valid, s_ready);
        end
        for (int k = 0; k < N; k++) if (out_s[k] !== 16'(k)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL basic_data: %0d wrong words (out5=%0d) required 0 (5)", bad, out_s[5]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_one_cycle: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
        tests++;
        if (short_cnt != s0 || long_cnt != l0) begin
            fails++;
            $display("FAIL basic_no_err: short=%0d long=%0d required 0 0",
                     short_cnt - s0, long_cnt - l0);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) push(16'(200 + i), i == N - 1);
        s_valid = 1'b1;
        in_s[0] = 16'd999;
        for (int c = 0; c < 10; c++) begin
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || out_s[0] !== 16'd200 ||
                out_s[N-1] !== 16'd239) bad++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d unstable cycles (out0=%0d) required 0 (200)", bad, out_s[0]);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        tests++;
        if (m_valid !== 1'b0 || out_s[0] !== 16'd200) begin
            fails++;
            $display("FAIL bp_release: m_valid=%b out0=%0d required 0 200", m_valid, out_s[0]);
        end
        for (int i = 0; i < N; i++) push(16'(50 + i), i == N - 1);
        tests++;
        if (m_valid !== 1'b1 || out_s[0] !== 16'd50 || out_s[N-1] !== 16'd89) begin
            fails++;
            $display("FAIL bp_next: m_valid=%b out0=%0d out39=%0d required 1 50 89",
                     m_valid, out_s[0], out_s[N-1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 25; i++) push(16'(700 + i), 1'b0);
        reset = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || out_s[3] !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid: s_ready=%b m_valid=%b out3=%0d required 1 0 0",
                     s_ready, m_valid, out_s[3]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N - 1; i++) push(16'(300 + i), 1'b0);
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_early_valid: m_valid=%b required 0", m_valid);
        end
        push(16'(300 + N - 1), 1'b1);
        tests++;
        if (m_valid !== 1'b1 || out_s[0] !== 16'd300 || out_s[24] !== 16'd324 ||
            out_s[N-1] !== 16'd339) begin
            fails++;
            $display("FAIL rst_new_frame: m_valid=%b out0=%0d out24=%0d out39=%0d req 1 300 324 339",
                     m_valid, out_s[0], out_s[24], out_s[N-1]);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef RESHAPE_INPUT_LAST_CHECK_EN
    task automatic test_short_frame();
        int s0 = short_cnt;
        int f0 = frame_cnt;
        for (int i = 0; i <= 20; i++) push(16'(i), i == 20);
        tests++;
        if (err_short !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL short_pulse: err_short=%b m_valid=%b required 1 0", err_short, m_valid);
        end
        for (int i = 0; i < N; i++) push(16'(100 + i), i == N - 1);
        tests++;
        if (m_valid !== 1'b1 || out_s[0] !== 16'd100 || out_s[N-1] !== 16'd139) begin
            fails++;
            $display("FAIL short_next: m_valid=%b out0=%0d out39=%0d required 1 100 139",
                     m_valid, out_s[0], out_s[N-1]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (short_cnt - s0 != 1 || frame_cnt - f0 != 1) begin
            fails++;
            $display("FAIL short_counts: pulses=%0d frames=%0d required 1 1",
                     short_cnt - s0, frame_cnt - f0);
        end
    endtask

    task automatic test_long_frame();
        int l0 = long_cnt;
        int f0 = frame_cnt;
        for (int i = 0; i < N; i++) push(16'(i), 1'b0);
        tests++;
        if (err_long !== 1'b1 || m_valid !== 1'b1 || out_s[N-1] !== 16'd39) begin
            fails++;
            $display("FAIL long_pulse: err_long=%b m_valid=%b out39=%0d required 1 1 39",
                     err_long, m_valid, out_s[N-1]);
        end
        for (int i = N; i <= 44; i++) push(16'(i), i == 44);
        for (int i = 0; i < N; i++) push(16'(500 + i), i == N - 1);
        tests++;
        if (m_valid !== 1'b1 || out_s[0] !== 16'd500 || out_s[N-1] !== 16'd539) begin
            fails++;
            $display("FAIL long_next: m_valid=%b out0=%0d out39=%0d required 1 500 539",
                     m_valid, out_s[0], out_s[N-1]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (long_cnt - l0 != 1 || frame_cnt - f0 != 2) begin
            fails++;
            $display("FAIL long_counts: pulses=%0d frames=%0d required 1 2",
                     long_cnt - l0, frame_cnt - f0);
        end
    endtask
`else
    task automatic test_last_ignored();
        int s0 = short_cnt;
        int l0 = long_cnt;
        int f0 = frame_cnt;
        m_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) push(16'(i), (i % 7) == 3);
        @(posedge clk);
        #1;
        tests++;
        if (frame_cnt - f0 != 2) begin
            fails++;
            $display("FAIL noerr_frames: frames=%0d required 2", frame_cnt - f0);
        end
        tests++;
        if (short_cnt != s0 || long_cnt != l0) begin
            fails++;
            $display("FAIL noerr_pulses: short=%0d long=%0d required 0 0",
                     short_cnt - s0, long_cnt - l0);
        end
        tests++;
        if (out_s[0] !== 16'd40 || out_s[N-1] !== 16'd79) begin
            fails++;
            $display("FAIL noerr_data: out0=%0d out39=%0d required 40 79", out_s[0], out_s[N-1]);
        end
    endtask
`endif

    initial begin
        in_s[0] = '0;
        #1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_reset_midframe();
`ifdef RESHAPE_INPUT_LAST_CHECK_EN
        test_short_frame();
        test_long_frame();
`else
        test_last_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reshape_input.md
# reshape_input

Stream-to-frame deserializer: accepts one WIDTH-bit sample per handshake on a valid/ready/last stream and assembles N_OUT consecutive samples into one parallel frame presented on a valid/ready output. It is the receive-side counterpart of the frame serializer in the strip pipeline. It feeds the frame-based processing stages (windowing/FFT) from the sample stream. The frame is handed off whole; no output beat carries a partial frame.

## Interface
- N_OUT, default 40: samples per frame; must be ≥ 2.
- WIDTH, default 16: sample width in bits.
- CNT_W, default $clog2(N_OUT): beat-counter width (derived; do not override).
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in  in  WIDTH × [1]  one-element unpacked sample array, valid with s_valid.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  block can accept a sample.
- s_last  in  1  marks the final sample of an upstream frame.
- out  out  WIDTH × [N_OUT]  assembled frame; out[0] is the first sample received.
- m_valid  out  1  frame on out is complete and held.
- m_ready  in  1  downstream accepts the frame.
- err_short  out  1  one-cycle pulse: s_last arrived before beat N_OUT-1.
- err_long  out  1  one-cycle pulse: beat N_OUT-1 arrived without s_last.

## Operation
- States: FILL, HOLD, DISCARD.
- Reset values: state=FILL, count=0, banks all 0, m_valid=0, err_short=0, err_long=0. s_ready=1 (combinational from FILL).
- s_ready = (state==FILL) || (state==DISCARD). m_valid = (state==HOLD). Both outputs are combinational from registered state only and never depend on s_valid or m_ready.
- FILL, accepted beat (s_valid & s_ready):
  - Write banks[count] <= in[0].
  - If count < N_OUT-1: count <= count+1.
  - If count == N_OUT-1: count <= 0, state <= HOLD.
- HOLD:
  - banks are frozen and out = banks.
  - On m_ready: state <= FILL, or DISCARD if the long-frame flag is set.
  - If m_ready is low, the block stays in HOLD indefinitely with out stable.
- DISCARD:
  - Accepted beats are dropped and banks are untouched.
  - An accepted beat with s_last clears the long-frame flag and sets state <= FILL.
- count never exceeds N_OUT-1. Wrap-around happens only on the final beat of a frame.

## Timing
- The frame becomes visible the cycle after the N_OUT-th accept: m_valid rises on the edge that registers the last sample.
- Minimum period is N_OUT+1 cycles per frame: N_OUT accept cycles plus one HOLD cycle with m_ready=1.
- A new sample is never accepted in the cycle m_valid & m_ready handshakes, because s_ready=0 in HOLD.
- Error pulses assert for exactly one cycle, in the cycle after the offending accept.
- Reset asserted mid-frame or in HOLD:
  - Partial and held frames are lost.
  - Outputs immediately take their reset values.
  - No error pulse is generated.

## Configuration
- Macro: RESHAPE_INPUT_LAST_CHECK_EN.
- Defined, short frame: s_last accepted in FILL with count < N_OUT-1 gives:
  - err_short pulse.
  - count <= 0, state stays FILL; the partial frame is discarded and never presented.
- Defined, long frame: the beat at count == N_OUT-1 accepted with s_last=0 gives:
  - err_long pulse.
  - The frame is presented normally.
  - The long-frame flag is set, so HOLD exits to DISCARD.
- Defined, exact frame: s_last on beat N_OUT-1 is the normal case and produces no error.
- Not defined:
  - s_last is ignored and DISCARD is unreachable.
  - err_short and err_long are tied 0; the ports remain present.
  - Every N_OUT accepted samples form a frame.

## Structure
- Shared package reshape_pkg holds:
  - the reshape_state_t enum {FILL, HOLD, DISCARD};
  - default constants RESHAPE_FRAME_LEN=40 and RESHAPE_SAMPLE_W=16, also used by the serializer.
- Single flat module with no sub-module: the bank register file and counter are too small to justify splitting.

## Test plan
- Reset, then 40 back-to-back beats with in=0..39 and s_last on beat 39, m_ready=1 → m_valid high for exactly one cycle, out[k]=k, s_ready=0 in that cycle, no error pulses.
- Same frame with m_ready=0 for 10 cycles → out held stable and s_valid ignored (s_ready=0) until m_ready rises; next frame starts at out[0].
- With LAST_CHECK_EN, s_last on beat 20, then a clean 40-beat frame 100..139 → err_short pulses once, the first partial frame is never presented, and the presented frame has out[0]=100.
- With LAST_CHECK_EN, 45 beats 0..44 with s_last on beat 44 → err_long pulses once, frame 0..39 presented, beats 40..44 dropped, and the next frame starts cleanly.
- Reset asserted at beat 25 of a frame, then released and a full 40-beat frame sent → no m_valid until beat 40 of the new frame, and the frame contains only new data.
- Without the macro, 80 beats with random s_last → two frames presented and err_short/err_long stay 0 throughout.
